// File: rtl/fp_round_pipe.sv
// fp_round_pipe: two-stage IEEE-754 mantissa rounder with valid/ready handshake.
// S1 decides the round increment; S2 applies it and renormalises on carry-out.
module fp_round_pipe #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int EXT_W  = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [MANT_W+EXT_W-1:0] in_mant,
    input  logic [2:0]              in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sign,
    output logic [EXP_W-1:0]        out_exp,
    output logic [MANT_W-1:0]       out_mant,
    output logic                    out_inexact,
    output logic                    out_overflow
);
    logic              s1_valid_q, s1_sign_q, s1_inc_q, s1_inexact_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [MANT_W-1:0] s1_mant_q;
    logic              s2_valid_q, s2_sign_q, s2_inexact_q, s2_overflow_q;
    logic [EXP_W-1:0]  s2_exp_q;
    logic [MANT_W-1:0] s2_mant_q;
    logic              s1_load, s2_load;
    logic              lsb, guard, sticky, special, inc_d, inexact_d;
    logic [MANT_W:0]   sum_d;
    logic [EXP_W-1:0]  exp_d;

    always_comb begin
        s2_load   = ~s2_valid_q | out_ready;
        s1_load   = ~s1_valid_q | s2_load;
        lsb       = in_mant[EXT_W];
        guard     = in_mant[EXT_W-1];
        sticky    = |in_mant[EXT_W-2:0];
        special   = &in_exp;
        inexact_d = ~special & (guard | sticky);
        // Inf/NaN inputs are truncated untouched, so the increment is suppressed
        inc_d     = special           ? 1'b0 :
                    in_mode == 3'd1   ? 1'b0 :
                    in_mode == 3'd2   ? in_sign & (guard | sticky) :
                    in_mode == 3'd3   ? ~in_sign & (guard | sticky) :
                    in_mode == 3'd4   ? guard :
                                        guard & (sticky | lsb);
        sum_d     = {1'b0, s1_mant_q} + (MANT_W+1)'(s1_inc_q);
        exp_d     = s1_exp_q + EXP_W'(sum_d[MANT_W]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_inc_q      <= 1'b0;
            s1_inexact_q  <= 1'b0;
            s1_exp_q      <= '0;
            s1_mant_q     <= '0;
            s2_valid_q    <= 1'b0;
            s2_sign_q     <= 1'b0;
            s2_inexact_q  <= 1'b0;
            s2_overflow_q <= 1'b0;
            s2_exp_q      <= '0;
            s2_mant_q     <= '0;
        end else begin
            if (s1_load) s1_valid_q <= in_valid;
            if (s1_load && in_valid) begin
                s1_sign_q    <= in_sign;
                s1_exp_q     <= in_exp;
                s1_mant_q    <= in_mant[MANT_W+EXT_W-1:EXT_W];
                s1_inc_q     <= inc_d;
                s1_inexact_q <= inexact_d;
            end
            if (s2_load) s2_valid_q <= s1_valid_q;
            // Result registers only change on a real transfer so flags hold their last value
            if (s2_load && s1_valid_q) begin
                s2_sign_q     <= s1_sign_q;
                s2_exp_q      <= exp_d;
                s2_mant_q     <= sum_d[MANT_W-1:0];
                s2_inexact_q  <= s1_inexact_q;
                s2_overflow_q <= sum_d[MANT_W] & (&exp_d);
            end
        end
    end

    assign in_ready     = s1_load;
    assign out_valid    = s2_valid_q;
    assign out_sign     = s2_sign_q;
    assign out_exp      = s2_exp_q;
    assign out_mant     = s2_mant_q;
    assign out_inexact  = s2_inexact_q;
    assign out_overflow = s2_overflow_q;
endmodule

// File: tb/tb_fp_round_pipe.sv
// tb_fp_round_pipe: directed and randomized checks of fp_round_pipe against an arithmetic rounding model.
module tb_fp_round_pipe;
    logic        clk = 0, reset_n = 0, in_valid = 0, in_sign = 0, out_ready = 0;
    logic [7:0]  in_exp = 0;
    logic [25:0] in_mant = 0;
    logic [2:0]  in_mode = 0;
    logic        in_ready, out_valid, out_sign, out_inexact, out_overflow;
    logic [7:0]  out_exp;
    logic [22:0] out_mant;
    int          errors = 0, checks = 0, inflight = 0;
    logic [33:0] exp_q[$], got_q[$];
    logic [33:0] obs_out;
    logic        obs_valid, obs_ready, exp_ready;

    always #5 clk = ~clk;

    fp_round_pipe dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
        .out_exp(out_exp), .out_mant(out_mant), .out_inexact(out_inexact),
        .out_overflow(out_overflow)
    );

    // Rounding by integer arithmetic on the kept part and the discarded remainder (in eighths of an ulp)
    function automatic logic [33:0] model(input logic s, input logic [7:0] e, input logic [25:0] m, input logic [2:0] md);
        int kept = int'(m >> 3);
        int rem  = int'(m & 26'd7);
        int ex   = int'(e);
        bit up;
        if (e == 8'hFF) return {s, e, 23'(kept), 2'b00};
        case (md)
            3'd1:    up = 0;
            3'd2:    up = s && rem != 0;
            3'd3:    up = !s && rem != 0;
            3'd4:    up = rem >= 4;
            default: up = rem > 4 || (rem == 4 && kept % 2 == 1);
        endcase
        kept += int'(up);
        if (kept == (1 << 23)) begin
            kept = 0;
            ex++;
        end
        return {s, 8'(ex), 23'(kept), rem != 0, ex == 255};
    endfunction

    task automatic cycle(input logic iv, input logic s, input logic [7:0] e, input logic [25:0] m,
                         input logic [2:0] md, input logic ordy);
        in_valid = iv; in_sign = s; in_exp = e; in_mant = m; in_mode = md; out_ready = ordy;
        #1;
        obs_ready = in_ready;
        obs_valid = out_valid;
        obs_out   = {out_sign, out_exp, out_mant, out_inexact, out_overflow};
        exp_ready = !(inflight == 2 && !ordy);
        if (iv && in_ready) begin
            exp_q.push_back(model(s, e, m, md));
            inflight++;
        end
        if (out_valid && ordy) begin
            got_q.push_back(obs_out);
            inflight--;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) cycle(0, 0, 0, 0, 0, 1);
    endtask

    task automatic run_one(input logic s, input logic [7:0] e, input logic [25:0] m, input logic [2:0] md,
                           output logic [33:0] g, output int lat);
        cycle(1, s, e, m, md, 1);
        lat = 0;
        g = 'x;
        while (got_q.size() == 0 && lat < 10) begin
            cycle(0, 0, 0, 0, 0, 1);
            lat++;
        end
        if (got_q.size() != 0) g = got_q.pop_front();
        exp_q.delete();
    endtask

    task automatic rand_item(output logic s, output logic [7:0] e, output logic [25:0] m, output logic [2:0] md);
        int k = int'($urandom_range(0, 5));
        s  = 1'($urandom);
        md = 3'($urandom);
        e  = k == 0 ? 8'h00 : k == 1 ? 8'hFE : k == 2 ? 8'hFF : 8'($urandom);
        m  = 26'($urandom);
        if ($urandom_range(0, 3) == 0) m[25:3] = '1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_inexact !== 1'b0 || out_overflow !== 1'b0 || out_mant !== 23'h0 || out_exp !== 8'h0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b x=%b o=%b e=%h m=%h want all 0", out_valid, out_inexact, out_overflow, out_exp, out_mant);
        end
        reset_n = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [71:0] tbl[15];
        string       nm[15];
        logic [33:0] g;
        int          lat;
        tbl[0]  = {1'b0, 8'h40, 23'h000001, 3'b100, 3'd0, 1'b0, 8'h40, 23'h000002, 1'b1, 1'b0}; nm[0]  = "rne_tie_odd";
        tbl[1]  = {1'b0, 8'h40, 23'h000002, 3'b100, 3'd0, 1'b0, 8'h40, 23'h000002, 1'b1, 1'b0}; nm[1]  = "rne_tie_even";
        tbl[2]  = {1'b0, 8'h40, 23'h000002, 3'b100, 3'd4, 1'b0, 8'h40, 23'h000003, 1'b1, 1'b0}; nm[2]  = "rmm_tie";
        tbl[3]  = {1'b0, 8'h10, 23'h7FFFFF, 3'b111, 3'd0, 1'b0, 8'h11, 23'h000000, 1'b1, 1'b0}; nm[3]  = "rne_carry";
        tbl[4]  = {1'b0, 8'h10, 23'h7FFFFF, 3'b111, 3'd1, 1'b0, 8'h10, 23'h7FFFFF, 1'b1, 1'b0}; nm[4]  = "rtz_carry";
        tbl[5]  = {1'b0, 8'hFE, 23'h7FFFFF, 3'b110, 3'd0, 1'b0, 8'hFF, 23'h000000, 1'b1, 1'b1}; nm[5]  = "overflow";
        tbl[6]  = {1'b0, 8'hFF, 23'h000000, 3'b111, 3'd0, 1'b0, 8'hFF, 23'h000000, 1'b0, 1'b0}; nm[6]  = "inf_pass";
        tbl[7]  = {1'b1, 8'h20, 23'h000010, 3'b001, 3'd3, 1'b1, 8'h20, 23'h000010, 1'b1, 1'b0}; nm[7]  = "neg_rup";
        tbl[8]  = {1'b1, 8'h20, 23'h000010, 3'b001, 3'd2, 1'b1, 8'h20, 23'h000011, 1'b1, 1'b0}; nm[8]  = "neg_rdn";
        tbl[9]  = {1'b0, 8'h20, 23'h000010, 3'b001, 3'd3, 1'b0, 8'h20, 23'h000011, 1'b1, 1'b0}; nm[9]  = "pos_rup";
        tbl[10] = {1'b0, 8'h20, 23'h000010, 3'b001, 3'd2, 1'b0, 8'h20, 23'h000010, 1'b1, 1'b0}; nm[10] = "pos_rdn";
        tbl[11] = {1'b0, 8'h40, 23'h000001, 3'b100, 3'd7, 1'b0, 8'h40, 23'h000002, 1'b1, 1'b0}; nm[11] = "mode7_rne";
        tbl[12] = {1'b0, 8'h00, 23'h7FFFFF, 3'b100, 3'd0, 1'b0, 8'h01, 23'h000000, 1'b1, 1'b0}; nm[12] = "denorm_carry";
        tbl[13] = {1'b0, 8'h30, 23'h000005, 3'b000, 3'd0, 1'b0, 8'h30, 23'h000005, 1'b0, 1'b0}; nm[13] = "exact";
        tbl[14] = {1'b1, 8'h30, 23'h000005, 3'b011, 3'd4, 1'b1, 8'h30, 23'h000005, 1'b1, 1'b0}; nm[14] = "rmm_below_half";
        for (int i = 0; i < 15; i++) begin
            run_one(tbl[i][71], tbl[i][70:63], tbl[i][62:37], tbl[i][36:34], g, lat);
            checks++;
            if (g !== tbl[i][33:0]) begin
                errors++;
                $display("FAIL %s got %h want %h", nm[i], g, tbl[i][33:0]);
            end
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL %s_latency got %0d want 2", nm[i], lat);
            end
        end
    endtask

    task automatic test_random();
        logic        s;
        logic [7:0]  e;
        logic [25:0] m;
        logic [2:0]  md;
        logic [33:0] g, x;
        for (int t = 0; t < 400; t++) begin
            rand_item(s, e, m, md);
            cycle($urandom_range(0, 3) != 0, s, e, m, md, $urandom_range(0, 2) != 0);
            checks++;
            if (obs_ready !== exp_ready) begin
                errors++;
                $display("FAIL random_in_ready t=%0d got %b want %b", t, obs_ready, exp_ready);
            end
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            g = got_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (g !== x) begin
                errors++;
                $display("FAIL random_item got %h want %h", g, x);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [33:0] held, g, x;
        logic        held_v = 0, ordy, saw_low = 0;
        int          sent = 0;
        for (int t = 0; t < 40 && (sent < 6 || got_q.size() < 6); t++) begin
            ordy = !(t >= 3 && t < 6);
            cycle(sent < 6, 1'(t), 8'h40 + 8'(sent), 26'($urandom), 3'(sent % 5), ordy);
            if (sent < 6 && obs_ready) sent++;
            if (!obs_ready) saw_low = 1;
            checks++;
            if (obs_ready !== exp_ready) begin
                errors++;
                $display("FAIL bp_in_ready t=%0d got %b want %b", t, obs_ready, exp_ready);
            end
            if (obs_valid && !ordy) begin
                if (held_v) begin
                    checks++;
                    if (obs_out !== held) begin
                        errors++;
                        $display("FAIL bp_stall_stable t=%0d got %h want %h", t, obs_out, held);
                    end
                end
                held = obs_out;
                held_v = 1;
            end else held_v = 0;
        end
        checks++;
        if (!saw_low) begin
            errors++;
            $display("FAIL bp_ready_drop got in_ready never low want low while full");
        end
        checks++;
        if (got_q.size() != 6 || exp_q.size() != 6) begin
            errors++;
            $display("FAIL bp_count got %0d want 6 (sent %0d)", got_q.size(), exp_q.size());
        end
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            g = got_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (g !== x) begin
                errors++;
                $display("FAIL bp_order got %h want %h", g, x);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        cycle(1, 0, 8'h40, {23'h000001, 3'b100}, 3'd0, 0);
        cycle(1, 1, 8'h41, {23'h000002, 3'b111}, 3'd0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre_valid got %b want 1", obs_valid);
        end
        reset_n = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_mant !== 23'h0 || out_inexact !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear got v=%b m=%h x=%b want 0", out_valid, out_mant, out_inexact);
        end
        @(posedge clk);
        #1;
        reset_n = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_ready got %b want 1", in_ready);
        end
        @(negedge clk);
        inflight = 0;
        got_q.delete();
        exp_q.delete();
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 0, 0, 0, 1);
            checks++;
            if (obs_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_stale k=%0d got out_valid %b want 0", k, obs_valid);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
